// File: rtl/pb_fb_dram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pb_fb_dram_arb_pkg
// Purpose  : Shared encodings for the framebuffer/CPU SDRAM burst arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package pb_fb_dram_arb_pkg;

   localparam int c_DEF_AW = 23;
   localparam int c_DEF_DW = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_BUSY = 2'd2
   } arb_state_t;

   typedef enum logic {
      GNT_M0 = 1'b0,
      GNT_M1 = 1'b1
   } grant_t;

endpackage
`default_nettype wire

// File: rtl/pb_fb_dram_arb.sv
`default_nettype none
// ============================================================================
// Module   : pb_fb_dram_arb
// Purpose  : Two-master SDRAM burst arbiter, video (M0) over CPU/L2 (M1).
//            Define PB_FB_ARB_STARVE_GUARD_EN to bound consecutive M0 grants
//            while M1 waits.
// Revision : 1.0 - initial release
// ============================================================================
module pb_fb_dram_arb
   import pb_fb_dram_arb_pkg::*;
#(
   parameter int AW         = c_DEF_AW,
   parameter int DW         = c_DEF_DW,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          m0_rd_req,
   output logic          m0_ack,
   input  logic [AW-1:0] m0_addr,
   output logic          m0_r_vld,
   input  logic          m1_rd_req,
   input  logic          m1_we_req,
   output logic          m1_ack,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_din,
   output logic          m1_r_vld,
   output logic          m1_w_rdy,
   output logic [DW-1:0] m_dout,
   output logic          sdr_cmd_bst_rd_req,
   output logic          sdr_cmd_bst_we_req,
   input  logic          sdr_cmd_bst_rd_ack,
   input  logic          sdr_cmd_bst_we_ack,
   output logic [AW-1:0] sdr_cmd_addr,
   output logic [DW-1:0] sdr_din,
   input  logic [DW-1:0] sdr_dout,
   input  logic          sdr_r_vld,
   input  logic          sdr_w_rdy
);

   if (STARVE_MAX < 1) begin : g_starve_max_chk
      $error("STARVE_MAX must be at least 1");
   end

   arb_state_t    r_state,  w_state_nxt;
   grant_t        r_grant,  w_grant_nxt;
   logic          r_rd_req, w_rd_req_nxt;
   logic          r_we_req, w_we_req_nxt;
   logic [AW-1:0] r_addr,   w_addr_nxt;
   logic          r_m0_ack, w_m0_ack_nxt;
   logic          r_m1_ack, w_m1_ack_nxt;
   logic          w_m1_wants;
   logic          w_sdr_ack;
   logic          w_starve_hit;

   assign w_m1_wants = m1_rd_req | m1_we_req;
   assign w_sdr_ack  = sdr_cmd_bst_rd_ack | sdr_cmd_bst_we_ack;

`ifdef PB_FB_ARB_STARVE_GUARD_EN
   localparam int c_CNT_W = $clog2(STARVE_MAX + 1);
   logic [c_CNT_W-1:0] r_starve_cnt, w_starve_cnt_nxt;
   assign w_starve_hit = w_m1_wants && (r_starve_cnt >= c_CNT_W'(STARVE_MAX));
`else
   assign w_starve_hit = 1'b0;
`endif

   always_comb begin
      w_state_nxt  = r_state;
      w_grant_nxt  = r_grant;
      w_rd_req_nxt = r_rd_req;
      w_we_req_nxt = r_we_req;
      w_addr_nxt   = r_addr;
      w_m0_ack_nxt = 1'b0;
      w_m1_ack_nxt = 1'b0;
`ifdef PB_FB_ARB_STARVE_GUARD_EN
      w_starve_cnt_nxt = r_starve_cnt;
`endif
      unique case (r_state)
         S_IDLE: begin
            // A starved M1 pre-empts M0; within M1 a read beats a write.
            if (w_starve_hit || (!m0_rd_req && w_m1_wants)) begin
               w_grant_nxt  = GNT_M1;
               w_rd_req_nxt = m1_rd_req;
               w_we_req_nxt = ~m1_rd_req;
               w_addr_nxt   = m1_addr;
               w_state_nxt  = S_REQ;
`ifdef PB_FB_ARB_STARVE_GUARD_EN
               w_starve_cnt_nxt = '0;
`endif
            end else if (m0_rd_req) begin
               w_grant_nxt  = GNT_M0;
               w_rd_req_nxt = 1'b1;
               w_we_req_nxt = 1'b0;
               w_addr_nxt   = m0_addr;
               w_state_nxt  = S_REQ;
`ifdef PB_FB_ARB_STARVE_GUARD_EN
               w_starve_cnt_nxt = w_m1_wants ? r_starve_cnt + 1'b1 : '0;
`endif
            end else begin
`ifdef PB_FB_ARB_STARVE_GUARD_EN
               w_starve_cnt_nxt = '0;
`endif
            end
         end
         S_REQ: begin
            if (w_sdr_ack) begin
               w_rd_req_nxt = 1'b0;
               w_we_req_nxt = 1'b0;
               w_m0_ack_nxt = (r_grant == GNT_M0);
               w_m1_ack_nxt = (r_grant == GNT_M1);
               w_state_nxt  = S_BUSY;
            end
         end
         S_BUSY: begin
            if (!w_sdr_ack) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_grant  <= GNT_M0;
         r_rd_req <= 1'b0;
         r_we_req <= 1'b0;
         r_addr   <= '0;
         r_m0_ack <= 1'b0;
         r_m1_ack <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_grant  <= w_grant_nxt;
         r_rd_req <= w_rd_req_nxt;
         r_we_req <= w_we_req_nxt;
         r_addr   <= w_addr_nxt;
         r_m0_ack <= w_m0_ack_nxt;
         r_m1_ack <= w_m1_ack_nxt;
      end
   end

`ifdef PB_FB_ARB_STARVE_GUARD_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_starve_cnt <= '0;
      end else begin
         r_starve_cnt <= w_starve_cnt_nxt;
      end
   end
`endif

   // Data handshakes are steered to the owner only while its burst is live.
   assign m0_r_vld = sdr_r_vld & (r_state == S_BUSY) & (r_grant == GNT_M0);
   assign m1_r_vld = sdr_r_vld & (r_state == S_BUSY) & (r_grant == GNT_M1);
   assign m1_w_rdy = sdr_w_rdy & (r_state == S_BUSY) & (r_grant == GNT_M1);

   assign m0_ack             = r_m0_ack;
   assign m1_ack             = r_m1_ack;
   assign sdr_cmd_bst_rd_req = r_rd_req;
   assign sdr_cmd_bst_we_req = r_we_req;
   assign sdr_cmd_addr       = r_addr;
   assign m_dout             = sdr_dout;
   assign sdr_din            = m1_din;

endmodule
`default_nettype wire

// File: tb/tb_pb_fb_dram_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pb_fb_dram_arb
// Purpose  : Randomised bench for pb_fb_dram_arb with a transaction-level
//            reference model and a bus-responder model of the SDRAM controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pb_fb_dram_arb;

   localparam int AW         = 23;
   localparam int DW         = 16;
   localparam int STARVE_MAX = 4;
   localparam int c_BEATS    = 32;
`ifdef PB_FB_ARB_STARVE_GUARD_EN
   localparam bit c_GUARD = 1'b1;
`else
   localparam bit c_GUARD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          m0_rd_req, m0_ack, m0_r_vld;
   logic [AW-1:0] m0_addr;
   logic          m1_rd_req, m1_we_req, m1_ack, m1_r_vld, m1_w_rdy;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_din, m_dout;
   logic          sdr_cmd_bst_rd_req, sdr_cmd_bst_we_req;
   logic          sdr_cmd_bst_rd_ack, sdr_cmd_bst_we_ack;
   logic [AW-1:0] sdr_cmd_addr;
   logic [DW-1:0] sdr_din, sdr_dout;
   logic          sdr_r_vld, sdr_w_rdy;

   pb_fb_dram_arb #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_rd_req(m0_rd_req), .m0_ack(m0_ack), .m0_addr(m0_addr), .m0_r_vld(m0_r_vld),
      .m1_rd_req(m1_rd_req), .m1_we_req(m1_we_req), .m1_ack(m1_ack), .m1_addr(m1_addr),
      .m1_din(m1_din), .m1_r_vld(m1_r_vld), .m1_w_rdy(m1_w_rdy), .m_dout(m_dout),
      .sdr_cmd_bst_rd_req(sdr_cmd_bst_rd_req), .sdr_cmd_bst_we_req(sdr_cmd_bst_we_req),
      .sdr_cmd_bst_rd_ack(sdr_cmd_bst_rd_ack), .sdr_cmd_bst_we_ack(sdr_cmd_bst_we_ack),
      .sdr_cmd_addr(sdr_cmd_addr), .sdr_din(sdr_din), .sdr_dout(sdr_dout),
      .sdr_r_vld(sdr_r_vld), .sdr_w_rdy(sdr_w_rdy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: who owns the DRAM and what it expects
   int            m_owner;   // -1 none, else master index
   int            m_stage;   // 0 free, 1 command offered, 2 data phase
   int            m_starve;
   bit            m_wr;
   logic [AW-1:0] m_addr;
   bit            e_rd, e_we, e_ack0, e_ack1;

   task automatic model_reset();
      m_owner = -1; m_stage = 0; m_starve = 0; m_wr = 1'b0; m_addr = '0;
      e_rd = 1'b0; e_we = 1'b0; e_ack0 = 1'b0; e_ack1 = 1'b0;
   endtask

   task automatic model_step();
      bit m1w;
      int win;
      e_ack0 = 1'b0;
      e_ack1 = 1'b0;
      m1w = m1_rd_req || m1_we_req;
      if (m_stage == 0) begin
         win = -1;
         if (c_GUARD && m1w && m_starve >= STARVE_MAX) win = 1;
         else if (m0_rd_req) win = 0;
         else if (m1w) win = 1;
         if (!m1w || win == 1) m_starve = 0;
         else if (win == 0) m_starve = m_starve + 1;
         if (win >= 0) begin
            m_owner = win;
            m_stage = 1;
            m_wr    = (win == 1) && !m1_rd_req;
            m_addr  = (win == 0) ? m0_addr : m1_addr;
            e_rd    = !m_wr;
            e_we    = m_wr;
         end
      end else if (m_stage == 1) begin
         if (sdr_cmd_bst_rd_ack || sdr_cmd_bst_we_ack) begin
            e_rd = 1'b0; e_we = 1'b0;
            e_ack0 = (m_owner == 0);
            e_ack1 = (m_owner == 1);
            m_stage = 2;
         end
      end else if (!sdr_cmd_bst_rd_ack && !sdr_cmd_bst_we_ack) begin
         m_stage = 0;
         m_owner = -1;
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_step();
      end
   end

   // ---------------- compare process and activity counters
   int cyc = 0, last_ack_cyc = 0, req_gap = -1;
   int cnt_m0_vld, cnt_m1_vld, cnt_w_rdy, cnt_m0_ack, cnt_m1_ack;
   int first_ack, m0_before_m1;
   int w_total = 0;
   bit prev_req = 1'b0;

   task automatic clr_counters();
      cnt_m0_vld = 0; cnt_m1_vld = 0; cnt_w_rdy = 0; cnt_m0_ack = 0; cnt_m1_ack = 0;
      first_ack = -1; m0_before_m1 = -1; req_gap = -1;
   endtask

   initial begin
      clr_counters();
      forever begin
         @(negedge clk);
         cyc++;
         chk("rd_req",  sdr_cmd_bst_rd_req, e_rd);
         chk("we_req",  sdr_cmd_bst_we_req, e_we);
         chk("addr",    sdr_cmd_addr, m_addr);
         chk("m0_ack",  m0_ack, e_ack0);
         chk("m1_ack",  m1_ack, e_ack1);
         chk("m0_r_vld", m0_r_vld, (m_stage == 2 && m_owner == 0 && sdr_r_vld));
         chk("m1_r_vld", m1_r_vld, (m_stage == 2 && m_owner == 1 && sdr_r_vld));
         chk("m1_w_rdy", m1_w_rdy, (m_stage == 2 && m_owner == 1 && sdr_w_rdy));
         chk("m_dout",  m_dout, sdr_dout);
         chk("sdr_din", sdr_din, m1_din);
         if (sdr_cmd_bst_rd_ack || sdr_cmd_bst_we_ack) last_ack_cyc = cyc;
         if ((sdr_cmd_bst_rd_req || sdr_cmd_bst_we_req) && !prev_req) req_gap = cyc - last_ack_cyc;
         prev_req = sdr_cmd_bst_rd_req || sdr_cmd_bst_we_req;
         if (m1_ack && m0_before_m1 < 0) m0_before_m1 = cnt_m0_ack;
         if (first_ack < 0 && m0_ack) first_ack = 0;
         if (first_ack < 0 && m1_ack) first_ack = 1;
         cnt_m0_vld += int'(m0_r_vld);
         cnt_m1_vld += int'(m1_r_vld);
         cnt_w_rdy  += int'(m1_w_rdy);
         w_total    += int'(m1_w_rdy);
         cnt_m0_ack += int'(m0_ack);
         cnt_m1_ack += int'(m1_ack);
      end
   end

   // ---------------- SDRAM controller responder
   int rsp_phase = 0, rsp_wait = 0, rsp_beats = 0, rsp_gaps = 0;
   bit rsp_wr = 1'b0;

   initial begin
      sdr_cmd_bst_rd_ack = 1'b0; sdr_cmd_bst_we_ack = 1'b0;
      sdr_r_vld = 1'b0; sdr_w_rdy = 1'b0; sdr_dout = '0;
      forever begin
         @(posedge clk); #1;
         sdr_r_vld = 1'b0;
         sdr_w_rdy = 1'b0;
         if (!rst_n) begin
            rsp_phase = 0;
            sdr_cmd_bst_rd_ack = 1'b0;
            sdr_cmd_bst_we_ack = 1'b0;
         end else begin
            case (rsp_phase)
               0: if (sdr_cmd_bst_rd_req || sdr_cmd_bst_we_req) begin
                     rsp_wr = sdr_cmd_bst_we_req;
                     rsp_wait = $urandom_range(0, 2);
                     rsp_phase = 1;
                  end
               1: if (rsp_wait == 0) begin
                     if (rsp_wr) sdr_cmd_bst_we_ack = 1'b1;
                     else sdr_cmd_bst_rd_ack = 1'b1;
                     rsp_beats = 0; rsp_gaps = 0; rsp_phase = 2;
                  end else rsp_wait--;
               default:
                  if (rsp_beats == c_BEATS) begin
                     sdr_cmd_bst_rd_ack = 1'b0;
                     sdr_cmd_bst_we_ack = 1'b0;
                     rsp_phase = 0;
                  end else if (rsp_gaps < 8 && $urandom_range(0, 3) == 0) begin
                     rsp_gaps++;
                  end else begin
                     rsp_beats++;
                     if (rsp_wr) sdr_w_rdy = 1'b1;
                     else begin
                        sdr_r_vld = 1'b1;
                        sdr_dout = DW'($urandom);
                     end
                  end
            endcase
         end
      end
   end

   // ---------------- masters: drop the granted request after its ack
   int m0_rate = 0, m1_rate = 0;

   initial begin
      forever begin
         @(posedge clk); #2;
         if (m0_ack) m0_rd_req = 1'b0;
         else if (!m0_rd_req && m0_rate > 0 && $urandom_range(1, 100) <= m0_rate) begin
            m0_rd_req = 1'b1;
            m0_addr = AW'($urandom);
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk); #2;
         m1_din = DW'(w_total);
         if (m1_ack) begin
            if (m1_rd_req) m1_rd_req = 1'b0;
            else m1_we_req = 1'b0;
         end else if (!m1_rd_req && !m1_we_req && m1_rate > 0 && $urandom_range(1, 100) <= m1_rate) begin
            case ($urandom_range(0, 2))
               0: m1_rd_req = 1'b1;
               1: m1_we_req = 1'b1;
               default: begin m1_rd_req = 1'b1; m1_we_req = 1'b1; end
            endcase
            m1_addr = AW'($urandom);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_quiet(input string name, input int budget);
      int q = 0;
      int n = 0;
      while (q < 2 && n < budget) begin
         tick(1);
         n++;
         if (m_stage == 0 && !m0_rd_req && !m1_rd_req && !m1_we_req) q++;
         else q = 0;
      end
      chk({name, "_settled"}, q >= 2, 1);
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      m0_rd_req = 1'b0; m0_addr = '0;
      m1_rd_req = 1'b0; m1_we_req = 1'b0; m1_addr = '0; m1_din = '0;
      tick(3);
      chk("rst_rd_req", sdr_cmd_bst_rd_req, 0);
      chk("rst_we_req", sdr_cmd_bst_we_req, 0);
      chk("rst_addr",   sdr_cmd_addr, 0);
      chk("rst_acks",   {m0_ack, m1_ack}, 0);
      chk("rst_vld",    {m0_r_vld, m1_r_vld, m1_w_rdy}, 0);
      rst_n = 1'b1;
      tick(2);

      // single M0 read burst
      clr_counters();
      m0_addr = 23'h000100; m0_rd_req = 1'b1;
      tick(1);
      chk("m0rd_req_next", sdr_cmd_bst_rd_req, 1);
      chk("m0rd_addr", sdr_cmd_addr, 23'h000100);
      wait_quiet("m0rd", 200);
      chk("m0rd_beats", cnt_m0_vld, 32);
      chk("m0rd_m1beats", cnt_m1_vld, 0);
      chk("m0rd_acks", cnt_m0_ack, 1);

      // simultaneous M0 and M1 reads
      clr_counters();
      m0_addr = 23'h000200; m0_rd_req = 1'b1;
      m1_addr = 23'h000300; m1_rd_req = 1'b1;
      wait_quiet("both", 300);
      chk("both_first", first_ack, 0);
      chk("both_gap", req_gap, 3);
      chk("both_m1_beats", cnt_m1_vld, 32);
      chk("both_m0_beats", cnt_m0_vld, 32);

      // M1 write burst
      clr_counters();
      m1_addr = 23'h000400; m1_we_req = 1'b1;
      wait_quiet("m1wr", 200);
      chk("m1wr_wrdy", cnt_w_rdy, 32);
      chk("m1wr_din_end", sdr_din, 32);
      chk("m1wr_m0vld", cnt_m0_vld + cnt_m1_vld, 0);
      chk("m1wr_acks", {cnt_m0_ack[7:0], cnt_m1_ack[7:0]}, 16'h0001);

      // continuous M0 traffic with M1 read pending
      clr_counters();
      m1_addr = 23'h000500; m1_rd_req = 1'b1;
      m0_rate = 100;
`ifdef PB_FB_ARB_STARVE_GUARD_EN
      n = 0;
      while (cnt_m1_ack == 0 && n < 700) begin tick(1); n++; end
      chk("starve_m0_bursts", m0_before_m1, 4);
`else
      n = 0;
      while (cnt_m0_ack < 8 && n < 900) begin tick(1); n++; end
      chk("strict_m0_bursts", cnt_m0_ack, 8);
      chk("strict_m1_never", cnt_m1_ack, 0);
`endif
      m0_rate = 0;
      wait_quiet("starve", 400);
      chk("starve_m1_served", cnt_m1_ack, 1);

      // reset in the middle of an M0 read burst
      clr_counters();
      m0_addr = 23'h000600; m0_rd_req = 1'b1;
      n = 0;
      while (cnt_m0_vld < 3 && n < 100) begin tick(1); n++; end
      chk("abort_reached_busy", cnt_m0_vld >= 3, 1);
      rst_n = 1'b0; m0_rd_req = 1'b0;
      #1;
      chk("abort_reqs", {sdr_cmd_bst_rd_req, sdr_cmd_bst_we_req}, 0);
      chk("abort_addr", sdr_cmd_addr, 0);
      chk("abort_outs", {m0_ack, m1_ack, m0_r_vld, m1_r_vld, m1_w_rdy}, 0);
      tick(1);
      rst_n = 1'b1;
      tick(1);
      clr_counters();
      m1_addr = 23'h000700; m1_rd_req = 1'b1;
      wait_quiet("abort_m1", 200);
      chk("abort_m1_beats", cnt_m1_vld, 32);
      chk("abort_m0_acks", cnt_m0_ack, 0);

      // random mixed traffic
      clr_counters();
      m0_rate = 20; m1_rate = 20;
      tick(3000);
      m0_rate = 0; m1_rate = 0;
      wait_quiet("random", 600);
      chk("random_activity", (cnt_m0_ack > 0) && (cnt_m1_ack > 0), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
